// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit active-low seven-segment driver with frame-synchronous double buffering.
// Optional build macro SEG7_LEAD_ZERO_BLANK_EN: auto-blank leading zero digits at each display load.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int GAP_CYC  = 2000
) (
  input  logic        GlobalClock,
  input  logic        RST,
  input  logic [31:0] DataIn,
  input  logic        DataValid,
  input  logic [7:0]  Blank,
  input  logic [7:0]  DpMask,
  output logic [7:0]  SEG,
  output logic [7:0]  NA,
  output logic        Frame
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_VAL = CNT_W'(GAP_CYC);

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  localparam state_t RST_STATE = (GAP_CYC == 0) ? ST_SHOW : ST_GAP;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dig_q, dig_d;
  logic [31:0]      sh_data_q, sh_data_d;
  logic [7:0]       sh_blank_q, sh_blank_d;
  logic [7:0]       sh_dp_q, sh_dp_d;
  logic             pending_q, pending_d;
  logic [31:0]      dp_data_q, dp_data_d;
  logic [7:0]       dp_blank_q, dp_blank_d;
  logic [7:0]       dp_dp_q, dp_dp_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       na_q, na_d;
  logic             frame_q, frame_d;

  logic slot_end;
  logic boundary;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Bit i set when nibbles i..7 are all zero; digit 0 always stays visible.
  function automatic logic [7:0] lead_zero_mask(input logic [31:0] d);
    logic [7:0] m;
    logic       zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      zero_above = zero_above & (d[4*i +: 4] == 4'h0);
      m[i]       = zero_above;
    end
    return LZB_EN ? m : 8'h00;
  endfunction

  assign slot_end = (cnt_q == CNT_MAX);
  assign boundary = slot_end && (dig_q == 3'd7);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    dig_d      = slot_end ? dig_q + 3'd1 : dig_q;
    state_d    = state_q;
    sh_data_d  = sh_data_q;
    sh_blank_d = sh_blank_q;
    sh_dp_d    = sh_dp_q;
    pending_d  = pending_q;
    dp_data_d  = dp_data_q;
    dp_blank_d = dp_blank_q;
    dp_dp_d    = dp_dp_q;
    seg_d      = 8'hFF;
    na_d       = 8'hFF;
    frame_d    = boundary;

    case (state_q)
      ST_GAP:  if (cnt_d >= GAP_VAL) state_d = ST_SHOW;
      ST_SHOW: if (cnt_d < GAP_VAL)  state_d = ST_GAP;
      default: state_d = RST_STATE;
    endcase

    if (state_q == ST_SHOW && !dp_blank_q[dig_q]) begin
      na_d  = ~(8'h01 << dig_q);
      seg_d = {~dp_dp_q[dig_q], hex7(dp_data_q[{dig_q, 2'b00} +: 4])};
    end

    // A strobe on the boundary bypasses the shadow so it is never lost or a frame late.
    if (boundary) begin
      if (DataValid) begin
        dp_data_d  = DataIn;
        dp_blank_d = Blank | lead_zero_mask(DataIn);
        dp_dp_d    = DpMask;
      end else if (pending_q) begin
        dp_data_d  = sh_data_q;
        dp_blank_d = sh_blank_q | lead_zero_mask(sh_data_q);
        dp_dp_d    = sh_dp_q;
      end
      pending_d = 1'b0;
    end else if (DataValid) begin
      sh_data_d  = DataIn;
      sh_blank_d = Blank;
      sh_dp_d    = DpMask;
      pending_d  = 1'b1;
    end
  end

  // NOTE: non-blocking assignments only, so all registers update together on the edge.
  always_ff @(posedge GlobalClock or posedge RST) begin
    if (RST) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      dig_q      <= '0;
      sh_data_q  <= '0;
      sh_blank_q <= '0;
      sh_dp_q    <= '0;
      pending_q  <= 1'b0;
      dp_data_q  <= '0;
      dp_blank_q <= '0;
      dp_dp_q    <= '0;
      seg_q      <= 8'hFF;
      na_q       <= 8'hFF;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      sh_data_q  <= sh_data_d;
      sh_blank_q <= sh_blank_d;
      sh_dp_q    <= sh_dp_d;
      pending_q  <= pending_d;
      dp_data_q  <= dp_data_d;
      dp_blank_q <= dp_blank_d;
      dp_dp_q    <= dp_dp_d;
      seg_q      <= seg_d;
      na_q       <= na_d;
      frame_q    <= frame_d;
    end
  end

  assign SEG   = seg_q;
  assign NA    = na_q;
  assign Frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed bench for seg7_scan_driver against a phase-based reference model.
// Honours SEG7_LEAD_ZERO_BLANK_EN in the model when the design is built with it.
module tb_seg7_scan_driver;

  localparam int SD    = 8;
  localparam int GC    = 2;
  localparam int FRAME = 8 * SD;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic        data_valid;
  logic [7:0]  blank;
  logic [7:0]  dp_mask;
  logic [7:0]  seg;
  logic [7:0]  na;
  logic        frame;

  seg7_scan_driver #(.SCAN_DIV(SD), .GAP_CYC(GC)) dut (
    .GlobalClock(clk),
    .RST        (rst),
    .DataIn     (data_in),
    .DataValid  (data_valid),
    .Blank      (blank),
    .DpMask     (dp_mask),
    .SEG        (seg),
    .NA         (na),
    .Frame      (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state: p counts clock edges since reset release.
  int          p;
  logic [31:0] m_data, s_data;
  logic [7:0]  m_blank, m_dp, s_blank, s_dp;
  bit          m_pend;
  logic [7:0]  e_seg, e_na;
  logic        e_frame;

  function automatic logic [7:0] lz_mask(input logic [31:0] d);
    logic [7:0] r;
    int top;
    r   = 8'h00;
    top = 0;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    for (int i = 0; i < 8; i++) if (d[4*i +: 4] != 4'h0) top = i;
    for (int i = 1; i < 8; i++) if (i > top) r[i] = 1'b1;
`endif
    return r;
  endfunction

  task automatic model_reset();
    p = 0; m_pend = 0;
    m_data = 0; m_blank = 0; m_dp = 0;
    s_data = 0; s_blank = 0; s_dp = 0;
  endtask

  task automatic model_step(input bit dv, input logic [31:0] d, input logic [7:0] b,
                            input logic [7:0] dm);
    int cnt, dig;
    bit bnd;
    cnt = p % SD;
    dig = (p / SD) % 8;
    bnd = (p % FRAME) == FRAME - 1;
    if (cnt < GC || m_blank[dig]) begin
      e_na = 8'hFF; e_seg = 8'hFF;
    end else begin
      e_na  = ~(8'd1 << dig);
      e_seg = {~m_dp[dig], hex_tab[m_data[4*dig +: 4]][6:0]};
    end
    e_frame = bnd;
    if (bnd) begin
      if (dv) begin
        m_data = d; m_blank = b | lz_mask(d); m_dp = dm;
      end else if (m_pend) begin
        m_data = s_data; m_blank = s_blank | lz_mask(s_data); m_dp = s_dp;
      end
      m_pend = 0;
    end else if (dv) begin
      s_data = d; s_blank = b; s_dp = dm; m_pend = 1;
    end
    p++;
  endtask

  // Drive inputs at the falling edge, advance one clock, compare at the next falling edge.
  task automatic cyc(input bit dv, input logic [31:0] d, input logic [7:0] b, input logic [7:0] dm);
    data_valid = dv; data_in = d; blank = b; dp_mask = dm;
    @(posedge clk);
    model_step(dv, d, b, dm);
    @(negedge clk);
    check("SEG", {24'h0, seg}, {24'h0, e_seg});
    check("NA", {24'h0, na}, {24'h0, e_na});
    check("Frame", {31'h0, frame}, {31'h0, e_frame});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 8'h0, 8'h0);
  endtask

  task automatic run_to_phase(input int ph);
    while ((p % FRAME) != ph) cyc(1'b0, 32'h0, 8'h0, 8'h0);
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] b, input logic [7:0] dm);
    cyc(1'b1, d, b, dm);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_SEG"}, {24'h0, seg}, 32'hFF);
    check({tag, "_NA"}, {24'h0, na}, 32'hFF);
    check({tag, "_Frame"}, {31'h0, frame}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_in = '0; blank = '0; dp_mask = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_hold");
    rst = 1'b0;

    // First lit cycle is the third after release.
    idle(2);
    check("first_dark_na", {24'h0, na}, 32'hFF);
    idle(1);
    check("first_lit_na", {24'h0, na}, 32'hFE);
    check("first_lit_seg", {24'h0, seg}, 32'hC0);

    // Load A1 with dp on digit 1 and watch two full frames.
    load(32'h0000_00A1, 8'h00, 8'h02);
    idle(2 * FRAME + 10);

    // Anti-tear: show 0, then load all ones mid-frame.
    load(32'h0, 8'h00, 8'h00);
    idle(FRAME + 4);
    run_to_phase(20);
    load(32'h1111_1111, 8'h00, 8'h00);
    idle(FRAME + 20);

    // Last-wins plus boundary bypass.
    run_to_phase(20);
    load(32'h2, 8'h00, 8'h00);
    run_to_phase(FRAME - 1);
    load(32'h5, 8'h00, 8'h00);
    idle(2 * FRAME);

    // Blank mask on digit 7.
    load(32'h1234_5678, 8'h80, 8'h00);
    idle(2 * FRAME);

    // Leading-zero candidates.
    load(32'h0000_00A1, 8'h00, 8'h00);
    idle(2 * FRAME);
    load(32'h0, 8'h00, 8'h00);
    idle(2 * FRAME);

    // Asynchronous reset mid-SHOW on digit 0 with data still pending.
    run_to_phase(4);
    load(32'hFFFF_FFFF, 8'h00, 8'hFF);
    idle(1);
    check("pre_reset_lit", {24'h0, na}, 32'hFE);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_edge");
    rst = 1'b0;
    model_reset();
    idle(2 * FRAME);

    // Randomized loads, including occasional strobes right on the boundary.
    for (int i = 0; i < 3000; i++) begin
      bit          dv;
      logic [31:0] d;
      logic [7:0]  b;
      dv = ($urandom_range(0, 11) == 0) || ((p % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 1);
      d  = $urandom >> (4 * $urandom_range(0, 7));
      b  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      cyc(dv, d, b, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
